// File: rtl/xalu_ise_ctrl.sv
// Sequences one custom instruction at a time into the combinational Ascon ISE ALU; rsp_valid rises EXEC_CYCLES
// edges after the accepting edge. A stalled response holds its data and blocks new requests until rsp_ready.
module xalu_ise_ctrl #(
  parameter int unsigned EXEC_CYCLES = 1,
  parameter int unsigned XLEN        = 64
) (
  input  logic            ise_clk,
  input  logic            ise_rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      req_fn,
  input  logic [6:0]      req_imm,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [4:0]      req_rd,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic [4:0]      rsp_rd,
  output logic            rsp_illegal,
  output logic [4:0]      ise_fn,
  output logic [6:0]      ise_imm,
  output logic [XLEN-1:0] ise_in1,
  output logic [XLEN-1:0] ise_in2,
  output logic            ise_val,
  input  logic            ise_oval,
  input  logic [XLEN-1:0] ise_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0]      fn;
    logic [6:0]      imm;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [4:0]      rd;
  } op_t;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [4:0]      rd;
    logic            illegal;
  } rsp_t;

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  op_t        op_q, op_d;
  rsp_t       rsp_q, rsp_d;
  logic       accept;

  // rsp_ready feeds req_ready combinationally so a draining response can overlap the next accept.
  always_comb begin
    req_ready = !flush && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
    accept    = req_valid && req_ready;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rsp_d   = rsp_q;

    unique case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_d.data    = ise_oval ? ise_out : '0;
          rsp_d.rd      = op_q.rd;
          rsp_d.illegal = !ise_oval;
          state_d       = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      op_d.fn  = req_fn;
      op_d.imm = req_imm;
      op_d.rs1 = req_rs1;
      op_d.rs2 = req_rs2;
      op_d.rd  = req_rd;
      cnt_d    = CNT_LOAD;
      state_d  = EXEC;
    end

    // Flush wins over both accept and a coinciding response handshake.
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge ise_clk) begin
    if (!ise_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rsp_q   <= rsp_d;
    end
  end

  always_comb begin
    rsp_valid   = (state_q == RESP);
    rsp_data    = rsp_q.data;
    rsp_rd      = rsp_q.rd;
    rsp_illegal = rsp_q.illegal;
    ise_val     = (state_q == EXEC);
    ise_fn      = op_q.fn;
    ise_imm     = op_q.imm;
    ise_in1     = op_q.rs1;
    ise_in2     = op_q.rs2;
  end

endmodule

// File: tb/tb_xalu_ise_ctrl.sv
// Bench for xalu_ise_ctrl: table vectors, directed corner sequences and a randomized transaction-level model.
module tb_xalu_ise_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, req_valid, rsp_ready, sel;
  logic [4:0]  req_fn, req_rd;
  logic [6:0]  req_imm;
  logic [63:0] req_rs1, req_rs2;

  logic        force1, f_oval;
  logic [63:0] f_out;
  logic [1:0]  mode4;
  int          xc4;

  logic        req_ready1, rsp_valid1, rsp_illegal1, ise_val1, ise_oval1;
  logic [63:0] rsp_data1, ise_in1_1, ise_in2_1, ise_out1;
  logic [4:0]  rsp_rd1, ise_fn1;
  logic [6:0]  ise_imm1;
  logic        req_ready4, rsp_valid4, rsp_illegal4, ise_val4, ise_oval4;
  logic [63:0] rsp_data4, ise_in1_4, ise_in2_4, ise_out4;
  logic [4:0]  rsp_rd4, ise_fn4;
  logic [6:0]  ise_imm4;

  int checks = 0;
  int errors = 0;

  function automatic logic [63:0] alu_ref(input logic [4:0] fn, input logic [6:0] imm,
                                          input logic [63:0] a, input logic [63:0] b);
    return (a ^ {b[31:0], b[63:32]}) + {52'd0, imm, fn};
  endfunction

  // Stub ALUs: u1 either forced or rule-based; u4 can claim only late or only early in EXEC.
  assign ise_oval1 = force1 ? f_oval : (ise_fn1[1:0] != 2'b00);
  assign ise_out1  = force1 ? f_out  : alu_ref(ise_fn1, ise_imm1, ise_in1_1, ise_in2_1);
  always @(posedge clk) xc4 <= ise_val4 ? xc4 + 1 : 0;
  assign ise_oval4 = (mode4 == 2'd1) ? (ise_val4 && xc4 == 3) :
                     (mode4 == 2'd2) ? (ise_val4 && xc4 < 3) : (ise_fn4[1:0] != 2'b00);
  assign ise_out4  = alu_ref(ise_fn4, ise_imm4, ise_in1_4, ise_in2_4);

  xalu_ise_ctrl #(.EXEC_CYCLES(1), .XLEN(64)) u1 (
    .ise_clk(clk), .ise_rst(rst_n), .flush(flush),
    .req_valid(req_valid & ~sel), .req_ready(req_ready1),
    .req_fn(req_fn), .req_imm(req_imm), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_data(rsp_data1), .rsp_rd(rsp_rd1),
    .rsp_illegal(rsp_illegal1), .ise_fn(ise_fn1), .ise_imm(ise_imm1), .ise_in1(ise_in1_1),
    .ise_in2(ise_in2_1), .ise_val(ise_val1), .ise_oval(ise_oval1), .ise_out(ise_out1)
  );

  xalu_ise_ctrl #(.EXEC_CYCLES(4), .XLEN(64)) u4 (
    .ise_clk(clk), .ise_rst(rst_n), .flush(flush),
    .req_valid(req_valid & sel), .req_ready(req_ready4),
    .req_fn(req_fn), .req_imm(req_imm), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_data(rsp_data4), .rsp_rd(rsp_rd4),
    .rsp_illegal(rsp_illegal4), .ise_fn(ise_fn4), .ise_imm(ise_imm4), .ise_in1(ise_in1_4),
    .ise_in2(ise_in2_4), .ise_val(ise_val4), .ise_oval(ise_oval4), .ise_out(ise_out4)
  );

  // Selected-instance views used by the generic tasks.
  logic        m_rr, m_rv, m_ill, m_iv;
  logic [63:0] m_data, m_in1, m_in2;
  logic [4:0]  m_rd, m_fn;
  logic [6:0]  m_imm;
  assign m_rr   = sel ? req_ready4   : req_ready1;
  assign m_rv   = sel ? rsp_valid4   : rsp_valid1;
  assign m_ill  = sel ? rsp_illegal4 : rsp_illegal1;
  assign m_iv   = sel ? ise_val4     : ise_val1;
  assign m_data = sel ? rsp_data4    : rsp_data1;
  assign m_in1  = sel ? ise_in1_4    : ise_in1_1;
  assign m_in2  = sel ? ise_in2_4    : ise_in2_1;
  assign m_rd   = sel ? rsp_rd4      : rsp_rd1;
  assign m_fn   = sel ? ise_fn4      : ise_fn1;
  assign m_imm  = sel ? ise_imm4     : ise_imm1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_op(input logic [4:0] fn, input logic [6:0] imm, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd);
    req_valid = 1'b1; req_fn = fn; req_imm = imm; req_rs1 = a; req_rs2 = b; req_rd = rd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [4:0]  fn;
    logic [6:0]  imm;
    logic [63:0] rs1, rs2;
    logic [4:0]  rd;
    bit          frc, oval;
    logic [63:0] out;
    logic [63:0] exp_data;
    bit          exp_ill;
  } vec_t;
  vec_t vecs[5];

  task automatic run_vec(input vec_t v, input int idx);
    string s;
    s = $sformatf("vec%0d", idx);
    @(negedge clk);
    force1 = v.frc; f_oval = v.oval; f_out = v.out;
    drive_op(v.fn, v.imm, v.rs1, v.rs2, v.rd);
    rsp_ready = 1'b0;
    #1 chk({s, "_req_ready"}, m_rr, 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk({s, "_ise_val"}, m_iv, 1);
    chk({s, "_rsp_valid_early"}, m_rv, 0);
    chk({s, "_ise_in"}, {m_fn, m_imm, m_in1[51:0]}, {v.fn, v.imm, v.rs1[51:0]});
    chk({s, "_ise_in2"}, m_in2, v.rs2);
    @(negedge clk);
    chk({s, "_ise_val_off"}, m_iv, 0);
    chk({s, "_rsp_valid"}, m_rv, 1);
    chk({s, "_rsp_data"}, m_data, v.exp_data);
    chk({s, "_rsp_rd"}, m_rd, v.rd);
    chk({s, "_rsp_illegal"}, m_ill, v.exp_ill);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({s, "_rsp_drop"}, m_rv, 0);
  endtask

  task automatic ec4_op(input logic [1:0] mode, input bit exp_ill);
    logic [63:0] a, b;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    sel = 1'b1; mode4 = mode;
    @(negedge clk);
    drive_op(5'b00100, 7'h11, a, b, 5'd9);
    #1 chk("ec4_req_ready", m_rr, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      chk("ec4_ise_val", m_iv, 1);
      chk("ec4_rsp_valid_early", m_rv, 0);
      chk("ec4_in1_stable", m_in1, a);
      chk("ec4_in2_stable", m_in2, b);
    end
    @(negedge clk);
    chk("ec4_ise_val_off", m_iv, 0);
    chk("ec4_rsp_valid", m_rv, 1);
    chk("ec4_illegal", m_ill, exp_ill);
    chk("ec4_data", m_data, exp_ill ? 64'd0 : alu_ref(5'b00100, 7'h11, a, b));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0; mode4 = 2'd0;
  endtask

  // Transaction-level reference: one op in flight; its response becomes visible ec+1 intervals after the
  // interval in which it was handshaken and stays until taken; flush discards it.
  task automatic run_random(input int ncyc, input bit s);
    int          ec, vis, nrsp;
    bit          busy, exp_rv, exp_iv, exp_rr, claim;
    logic [4:0]  o_fn, o_rd;
    logic [6:0]  o_imm;
    logic [63:0] o_a, o_b;
    sel = s; ec = s ? 4 : 1; busy = 0; vis = 0; nrsp = 0;
    o_fn = '0; o_rd = '0; o_imm = '0; o_a = '0; o_b = '0;
    do_reset();
    for (int t = 0; t < ncyc; t++) begin
      @(negedge clk);
      exp_rv = busy && (t >= vis);
      exp_iv = busy && (t < vis);
      chk("rnd_rsp_valid", m_rv, exp_rv);
      chk("rnd_ise_val", m_iv, exp_iv);
      if (exp_rv) begin
        claim = (o_fn[1:0] != 2'b00);
        chk("rnd_rsp_data", m_data, claim ? alu_ref(o_fn, o_imm, o_a, o_b) : 64'd0);
        chk("rnd_rsp_rd", m_rd, o_rd);
        chk("rnd_rsp_illegal", m_ill, !claim);
      end
      if (exp_iv) chk("rnd_ise_ops", {m_fn, m_imm, m_in1 ^ m_in2}, {o_fn, o_imm, o_a ^ o_b});
      drive_op(5'($urandom), 7'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom));
      req_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      #1;
      exp_rr = !flush && (!busy || (exp_rv && rsp_ready));
      chk("rnd_req_ready", m_rr, exp_rr);
      if (flush) busy = 0;
      else begin
        if (exp_rv && rsp_ready) begin busy = 0; nrsp++; end
        if (req_valid && exp_rr) begin
          busy = 1; vis = t + 1 + ec;
          o_fn = req_fn; o_imm = req_imm; o_a = req_rs1; o_b = req_rs2; o_rd = req_rd;
        end
      end
    end
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b0;
    if (nrsp == 0) chk("rnd_no_responses", 0, 1);
  endtask

  logic [4:0]  bb_fn[3];
  logic [4:0]  bb_rd[3];
  logic [63:0] bb_a[3];
  logic [63:0] bb_b[3];
  logic [63:0] hold;

  initial begin
    sel = 1'b0; force1 = 1'b0; f_oval = 1'b0; f_out = '0; mode4 = 2'd0;
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_fn = '0; req_imm = '0; req_rs1 = '0; req_rs2 = '0; req_rd = '0;

    vecs[0] = '{5'b00001, 7'b1000011, 64'h1111, 64'h2222, 5'd7, 1, 1, 64'h0123_4567_89AB_CDEF,
                64'h0123_4567_89AB_CDEF, 0};
    vecs[1] = '{5'b00000, 7'd0, 64'h3333, 64'h4444, 5'd12, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
    vecs[2] = '{5'b10110, 7'h5A, 64'hDEAD_BEEF_0000_FFFF, 64'h0F0F_0F0F_1234_5678, 5'd31, 0, 0, 64'd0,
                alu_ref(5'b10110, 7'h5A, 64'hDEAD_BEEF_0000_FFFF, 64'h0F0F_0F0F_1234_5678), 0};
    vecs[3] = '{5'b11100, 7'h7F, 64'hAAAA, 64'h5555, 5'd0, 0, 0, 64'd0, 64'd0, 1};
    vecs[4] = '{5'b00011, 7'h01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 5'd1, 0, 0, 64'd0,
                alu_ref(5'b00011, 7'h01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0), 0};

    do_reset();
    @(negedge clk);
    chk("rst_req_ready1", req_ready1, 1);
    chk("rst_rsp_valid", {rsp_valid1, rsp_valid4}, 0);
    chk("rst_ise_val", {ise_val1, ise_val4}, 0);
    chk("rst_rsp_illegal", {rsp_illegal1, rsp_illegal4}, 0);
    chk("rst_rsp_data", rsp_data1 | rsp_data4, 0);
    chk("rst_ise_ops", {ise_fn1, ise_imm1, rsp_rd1, ise_fn4}, 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);
    force1 = 1'b0;

    // Backpressure: the response holds for 5 stalled cycles while a second request waits.
    @(negedge clk);
    drive_op(5'b00010, 7'h22, 64'h1234, 64'h5678, 5'd3);
    @(negedge clk);
    drive_op(5'b00001, 7'h33, 64'h9999, 64'h8888, 5'd4);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid", m_rv, 1);
      chk("bp_rsp_data", m_data, alu_ref(5'b00010, 7'h22, 64'h1234, 64'h5678));
      chk("bp_rsp_rd", m_rd, 3);
      chk("bp_req_ready", m_rr, 0);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_single_hs", {m_rv, m_iv}, 0);
    @(negedge clk);
    chk("bp_no_second", {m_rv, m_iv}, 0);

    // Back-to-back: three ops, alternating EXEC/RESP with no idle gap.
    for (int i = 0; i < 3; i++) begin
      bb_fn[i] = 5'(i + 1); bb_rd[i] = 5'(10 + i); bb_a[i] = {$urandom, $urandom}; bb_b[i] = {$urandom, $urandom};
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    drive_op(bb_fn[0], 7'h05, bb_a[0], bb_b[0], bb_rd[0]);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("b2b_ise_val", m_iv, (j % 2) == 0);
      chk("b2b_rsp_valid", m_rv, (j % 2) == 1);
      if (j % 2 == 1) begin
        chk("b2b_rsp_rd", m_rd, bb_rd[j/2]);
        chk("b2b_rsp_data", m_data, alu_ref(bb_fn[j/2], 7'h05, bb_a[j/2], bb_b[j/2]));
        if (j / 2 < 2) drive_op(bb_fn[j/2+1], 7'h05, bb_a[j/2+1], bb_b[j/2+1], bb_rd[j/2+1]);
        else req_valid = 1'b0;
      end
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("b2b_end_idle", {m_rv, m_iv}, 0);

    // EXEC_CYCLES=4: claim only in the last cycle is legal; claim only earlier is illegal.
    ec4_op(2'd1, 0);
    ec4_op(2'd2, 1);
    sel = 1'b0;

    // Flush during EXEC.
    @(negedge clk);
    drive_op(5'b00001, 7'h01, 64'h77, 64'h66, 5'd5);
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b1;
    #1 chk("flx_req_ready", m_rr, 0);
    @(negedge clk);
    flush = 1'b0;
    chk("flx_dropped", {m_rv, m_iv}, 0);
    @(negedge clk);
    chk("flx_no_rsp", {m_rv, m_iv}, 0);

    // Flush in RESP with rsp_ready and a new request all asserted.
    drive_op(5'b00001, 7'h02, 64'h55, 64'h44, 5'd6);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("flr_in_resp", m_rv, 1);
    drive_op(5'b00010, 7'h03, 64'h12, 64'h34, 5'd8);
    rsp_ready = 1'b1; flush = 1'b1;
    #1 chk("flr_req_ready", m_rr, 0);
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    chk("flr_idle", {m_rv, m_iv}, 0);

    // Reset during EXEC returns every output to zero.
    @(negedge clk);
    drive_op(5'b00011, 7'h7E, 64'hCAFE, 64'hF00D, 5'd21);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rx_in_exec", m_iv, 1);
    hold = rsp_data1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rx_prior_data_nonzero", hold != 64'd0, 1);
    chk("rx_flags", {rsp_valid1, ise_val1, rsp_illegal1}, 0);
    chk("rx_data", rsp_data1, 0);
    chk("rx_ops", {ise_fn1, ise_imm1, rsp_rd1}, 0);
    chk("rx_in", ise_in1_1 | ise_in2_1, 0);

    run_random(1500, 1'b0);
    run_random(1500, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
